// File: rtl/controle_cedulas_pkg.sv
// Shared types for the bill-acceptor credit controller: FSM states, bill codes
// and the code-to-reais conversion.
package controle_cedulas_pkg;

  typedef enum logic [1:0] {
    OCIOSO,
    ACUMULANDO,
    VENDENDO,
    DEVOLVENDO
  } estado_t;

  localparam logic [1:0] CED_2  = 2'b00;
  localparam logic [1:0] CED_5  = 2'b01;
  localparam logic [1:0] CED_10 = 2'b10;
  localparam logic [1:0] CED_20 = 2'b11;

  function automatic logic [6:0] valor_reais(input logic [1:0] codigo);
    logic [6:0] v;
    case (codigo)
      CED_2:   v = 7'd2;
      CED_5:   v = 7'd5;
      CED_10:  v = 7'd10;
      CED_20:  v = 7'd20;
      default: v = 7'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/controle_cedulas_contador_tempo.sv
// Loadable down-counter that stops at zero; zero flag is a decode of the count.
module contador_tempo #(
  parameter int LARGURA = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               carga,
  input  logic               habilita,
  input  logic [LARGURA-1:0] valor,
  output logic               zero
);

  logic [LARGURA-1:0] contagem;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      contagem <= '0;
    end else if (carga) begin
      contagem <= valor;
    end else if (habilita && contagem != '0) begin
      contagem <= contagem - LARGURA'(1);
    end
  end

  assign zero = (contagem == '0);

endmodule

// File: rtl/controle_cedulas.sv
// Credit controller for a bill-accepting vending machine.
// Optional inactivity auto-return is enabled by defining TIMEOUT_EN.
module controle_cedulas
  import controle_cedulas_pkg::*;
#(
  parameter int CREDITO_MAX    = 99,
  parameter int DEVOLVE_CICLOS = 4,
  parameter int TIMEOUT_CICLOS = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cedula_valida,
  input  logic [1:0] valor_cedula,
  input  logic       produto_sel,
  input  logic [6:0] preco,
  input  logic       botao_cancelar,
  output logic [6:0] credito,
  output logic [6:0] troco,
  output logic       devolver_dinheiro,
  output logic       liberar_produto,
  output logic       cedula_rejeitada,
  output logic       falta_credito,
  output logic       ocupado
);

  localparam int DW = $clog2(DEVOLVE_CICLOS + 1);

  if (DEVOLVE_CICLOS < 1 || TIMEOUT_CICLOS < 1) begin : g_parametros_invalidos
    $error("controle_cedulas: DEVOLVE_CICLOS and TIMEOUT_CICLOS must be >= 1");
  end

  estado_t    estado;
  logic [6:0] valor;
  logic [7:0] soma;
  logic       cabe;
  logic       preco_ok;
  logic       livre;
  logic       cancela;
  logic       compra;
  logic       deposito;
  logic       carga_dev;
  logic       fim_dev;
  logic       expirou;

  always_comb begin
    valor    = valor_reais(valor_cedula);
    soma     = {1'b0, credito} + {1'b0, valor};
    cabe     = (soma <= 8'(CREDITO_MAX));
    preco_ok = (preco != '0) && (credito >= preco);
    livre    = (estado == OCIOSO) || (estado == ACUMULANDO);
    // Only the highest-priority live request is acted on; a bill that loses is refused.
    cancela  = (estado == ACUMULANDO) && (botao_cancelar || expirou);
    compra   = livre && produto_sel && !cancela;
    deposito = livre && cedula_valida && !cancela && !compra;
    carga_dev = cancela || ((estado == VENDENDO) && (troco != '0));
  end

  contador_tempo #(.LARGURA(DW)) u_devolucao (
    .clk      (clk),
    .rst_n    (rst_n),
    .carga    (carga_dev),
    .habilita (estado == DEVOLVENDO),
    .valor    (DW'(DEVOLVE_CICLOS - 1)),
    .zero     (fim_dev)
  );

`ifdef TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
  logic atividade;
  logic zero_inat;

  assign atividade = cedula_valida || produto_sel || botao_cancelar;

  contador_tempo #(.LARGURA(TW)) u_inatividade (
    .clk      (clk),
    .rst_n    (rst_n),
    .carga    ((estado != ACUMULANDO) || atividade),
    .habilita (1'b1),
    .valor    (TW'(TIMEOUT_CICLOS - 1)),
    .zero     (zero_inat)
  );

  assign expirou = (estado == ACUMULANDO) && !atividade && zero_inat;
`else
  assign expirou = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado            <= OCIOSO;
      credito           <= '0;
      troco             <= '0;
      devolver_dinheiro <= 1'b0;
      liberar_produto   <= 1'b0;
      cedula_rejeitada  <= 1'b0;
      falta_credito     <= 1'b0;
      ocupado           <= 1'b0;
    end else begin
      liberar_produto  <= 1'b0;
      cedula_rejeitada <= cedula_valida && !(deposito && cabe);
      falta_credito    <= compra && !((estado == ACUMULANDO) && preco_ok);
      case (estado)
        OCIOSO, ACUMULANDO: begin
          if (cancela) begin
            troco             <= credito;
            credito           <= '0;
            devolver_dinheiro <= 1'b1;
            ocupado           <= 1'b1;
            estado            <= DEVOLVENDO;
          end else if (compra && (estado == ACUMULANDO) && preco_ok) begin
            troco           <= credito - preco;
            credito         <= '0;
            liberar_produto <= 1'b1;
            ocupado         <= 1'b1;
            estado          <= VENDENDO;
          end else if (deposito && cabe) begin
            credito <= soma[6:0];
            estado  <= ACUMULANDO;
          end
        end
        VENDENDO: begin
          if (troco != '0) begin
            devolver_dinheiro <= 1'b1;
            estado            <= DEVOLVENDO;
          end else begin
            ocupado <= 1'b0;
            estado  <= OCIOSO;
          end
        end
        DEVOLVENDO: begin
          if (fim_dev) begin
            devolver_dinheiro <= 1'b0;
            troco             <= '0;
            ocupado           <= 1'b0;
            estado            <= OCIOSO;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/controle_cedulas.md
CONTROLE_CEDULAS -- requirements
Module: controle_cedulas

Interface
REQ-001 Parameters SHALL be:
- CREDITO_MAX, default 99: credit ceiling in reais.
- DEVOLVE_CICLOS, default 4: cycles devolver_dinheiro is held high.
- TIMEOUT_CICLOS, default 1000: inactivity cycles before auto-return (used only with TIMEOUT_EN).
REQ-002 Ports SHALL be:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- cedula_valida  in  1  one-cycle pulse; a bill was accepted by the reader.
- valor_cedula  in  2  bill code: 00=R$2, 01=R$5, 10=R$10, 11=R$20.
- produto_sel  in  1  one-cycle purchase request pulse.
- preco  in  7  price of the selected product, sampled with produto_sel.
- botao_cancelar  in  1  one-cycle cancel pulse.
- credito  out  7  current credit in reais.
- troco  out  7  amount being returned; valid while devolver_dinheiro=1.
- devolver_dinheiro  out  1  return command to the downstream note-return/LED stage.
- liberar_produto  out  1  one-cycle dispense pulse.
- cedula_rejeitada  out  1  one-cycle pulse; bill refused.
- falta_credito  out  1  one-cycle pulse; purchase refused.
- ocupado  out  1  high in VENDENDO and DEVOLVENDO.

Function
REQ-003 FSM states SHALL be OCIOSO, ACUMULANDO, VENDENDO, DEVOLVENDO; all outputs registered, responding one cycle after the sampled input.
REQ-004 OCIOSO/ACUMULANDO + cedula_valida: if credito+valor <= CREDITO_MAX, credito += valor and state -> ACUMULANDO; otherwise credito unchanged and cedula_rejeitada pulses.
REQ-005 ACUMULANDO + produto_sel: if preco != 0 and credito >= preco -> VENDENDO, troco = credito-preco, credito = 0; otherwise falta_credito pulses and state is unchanged.
REQ-006 VENDENDO SHALL last one cycle with liberar_produto=1, then -> DEVOLVENDO if troco>0, else -> OCIOSO.
REQ-007 ACUMULANDO + botao_cancelar SHALL set troco = credito, credito = 0, state -> DEVOLVENDO; cancel in OCIOSO (credito=0) is ignored.
REQ-008 DEVOLVENDO SHALL hold devolver_dinheiro=1 for exactly DEVOLVE_CICLOS cycles, then clear troco and go -> OCIOSO.
REQ-009 Same-cycle priority SHALL be botao_cancelar > produto_sel > cedula_valida; the losing bill pulses cedula_rejeitada.
REQ-010 While ocupado=1: cedula_valida SHALL pulse cedula_rejeitada; produto_sel and botao_cancelar SHALL be ignored.
REQ-011 produto_sel in OCIOSO SHALL pulse falta_credito.
REQ-012 Arithmetic SHALL be 7-bit unsigned; credito never exceeds CREDITO_MAX and troco never underflows.

Reset
REQ-013 rst_n=0 at a clock edge SHALL force OCIOSO, credito=0, troco=0, all pulse outputs 0, timers cleared, including mid-DEVOLVENDO (return aborted).

Configuration
REQ-014 With TIMEOUT_EN defined: in ACUMULANDO, TIMEOUT_CICLOS consecutive cycles without cedula_valida, produto_sel or botao_cancelar SHALL behave as botao_cancelar; any of those inputs reloads the timer.
REQ-015 Without TIMEOUT_EN: no timer logic; credit is held indefinitely.

Structure
REQ-016 Package controle_cedulas_pkg SHALL hold the state enum, bill-code constants, and the code-to-reais value function.
REQ-017 One sub-module, contador_tempo (loadable down-counter with zero flag), SHALL be instantiated for the DEVOLVE hold and, if TIMEOUT_EN is defined, for the inactivity timeout.

Verification
REQ-018 Bills 11,01 then produto_sel preco=18 -> credito 20, 25; liberar_produto pulse; troco=7; devolver_dinheiro high for 4 cycles; then OCIOSO.
REQ-019 Credit 90 + bill 11 -> cedula_rejeitada pulse, credito stays 90.
REQ-020 Credit 5, produto_sel preco=10 -> falta_credito pulse, credito stays 5, state ACUMULANDO.
REQ-021 Same-cycle cancel, produto_sel and bill with credito=12 -> troco=12, cedula_rejeitada pulse, no liberar_produto.
REQ-022 rst_n low during DEVOLVENDO cycle 2 -> next cycle devolver_dinheiro=0, troco=0, credito=0.
REQ-023 TIMEOUT_EN with TIMEOUT_CICLOS=8, credito=2, idle 8 cycles -> devolver_dinheiro high with troco=2; without the macro -> credito stays 2.
